// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: per-register stall codes and fetch-discard FSM.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_stall_req,
  input  logic        if_busy,
  input  logic        id_stall_req,
  input  logic        mem_stall_req,
  input  logic        branch_error,
  output logic [1:0]  stall_pc,
  output logic [1:0]  stall_ifid,
  output logic [1:0]  stall_idex,
  output logic [1:0]  stall_exmem,
  output logic [1:0]  stall_memwb,
  output logic        flush_if,
  output logic [31:0] cnt_cycle,
  output logic [31:0] cnt_mem_stall,
  output logic [31:0] cnt_id_stall,
  output logic [31:0] cnt_if_stall,
  output logic [31:0] cnt_flush
);

  localparam logic [1:0] Pass = 2'b00;
  localparam logic [1:0] Hold = 2'b01;
  localparam logic [1:0] Bubb = 2'b10;

  typedef enum logic {RUN, DRAIN} state_t;

  typedef enum logic [2:0] {
    R_RST, R_FRZ, R_MEM, R_BR, R_DRN, R_ID, R_IF, R_RUN
  } rule_t;

  state_t state_q, state_d;
  rule_t  rule;

  always_comb begin
    rule = R_RUN;
    if (rst)                 rule = R_RST;
    else if (!rdy)           rule = R_FRZ;
    else if (mem_stall_req)  rule = R_MEM;
    else if (branch_error)   rule = R_BR;
    else if (state_q == DRAIN) rule = R_DRN;
    else if (id_stall_req)   rule = R_ID;
    else if (if_stall_req)   rule = R_IF;
  end

  // A stalled branch is not acted on here; EX re-presents it once MEM releases.
  always_comb begin
    stall_pc    = Pass;
    stall_ifid  = Pass;
    stall_idex  = Pass;
    stall_exmem = Pass;
    stall_memwb = Pass;
    flush_if    = 1'b0;
    state_d     = state_q;
    case (rule)
      R_RST: begin
        stall_pc    = Bubb;
        stall_ifid  = Bubb;
        stall_idex  = Bubb;
        stall_exmem = Bubb;
        stall_memwb = Bubb;
        state_d     = RUN;
      end
      R_FRZ: begin
        stall_pc    = Hold;
        stall_ifid  = Hold;
        stall_idex  = Hold;
        stall_exmem = Hold;
        stall_memwb = Hold;
      end
      R_MEM: begin
        stall_pc    = Hold;
        stall_ifid  = Hold;
        stall_idex  = Hold;
        stall_exmem = Hold;
        stall_memwb = Bubb;
      end
      R_BR: begin
        stall_ifid = Bubb;
        stall_idex = Bubb;
        flush_if   = if_busy;
        state_d    = if_busy ? DRAIN : RUN;
      end
      R_DRN: begin
        stall_pc   = Hold;
        stall_ifid = Bubb;
        state_d    = if_busy ? DRAIN : RUN;
      end
      R_ID: begin
        stall_pc   = Hold;
        stall_ifid = Hold;
        stall_idex = Bubb;
      end
      R_IF: begin
        stall_pc   = Hold;
        stall_ifid = Bubb;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cyc_q, mem_q, id_q, if_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q   <= 32'd0;
      mem_q   <= 32'd0;
      id_q    <= 32'd0;
      if_q    <= 32'd0;
      flush_q <= 32'd0;
    end else if (rdy) begin
      cyc_q <= cyc_q + 32'd1;
      if (rule == R_MEM) mem_q   <= mem_q + 32'd1;
      if (rule == R_ID)  id_q    <= id_q + 32'd1;
      if (rule == R_IF)  if_q    <= if_q + 32'd1;
      if (rule == R_BR)  flush_q <= flush_q + 32'd1;
    end
  end

  assign cnt_cycle     = cyc_q;
  assign cnt_mem_stall = mem_q;
  assign cnt_id_stall  = id_q;
  assign cnt_if_stall  = if_q;
  assign cnt_flush     = flush_q;
`else
  assign cnt_cycle     = 32'd0;
  assign cnt_mem_stall = 32'd0;
  assign cnt_id_stall  = 32'd0;
  assign cnt_if_stall  = 32'd0;
  assign cnt_flush     = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic against a rule-table model.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, if_stall_req, if_busy, id_stall_req, mem_stall_req, branch_error;
  logic [1:0]  stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb;
  logic        flush_if;
  logic [31:0] cnt_cycle, cnt_mem_stall, cnt_id_stall, cnt_if_stall, cnt_flush;

  int n_vec = 0;
  int n_bad = 0;

  // model state: whether a redirected fetch is still being discarded, plus event tallies
  bit          m_drain = 1'b0;
  logic [31:0] m_cyc = 0, m_mem = 0, m_id = 0, m_if = 0, m_fl = 0;

  // stimulus word: {rst, rdy, if_stall, if_busy, id_stall, mem_stall, branch}
  localparam logic [6:0] IDLE  = 7'b0100000;
  localparam logic [6:0] IDST  = 7'b0100100;
  localparam logic [6:0] MEMBR = 7'b0100011;
  localparam logic [6:0] BRB   = 7'b0101001;
  localparam logic [6:0] BUSY  = 7'b0101000;
  localparam logic [6:0] FRZB  = 7'b0001000;
  localparam logic [6:0] RSTB  = 7'b1101000;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .if_stall_req(if_stall_req), .if_busy(if_busy),
    .id_stall_req(id_stall_req), .mem_stall_req(mem_stall_req), .branch_error(branch_error),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .stall_exmem(stall_exmem), .stall_memwb(stall_memwb), .flush_if(flush_if),
    .cnt_cycle(cnt_cycle), .cnt_mem_stall(cnt_mem_stall), .cnt_id_stall(cnt_id_stall),
    .cnt_if_stall(cnt_if_stall), .cnt_flush(cnt_flush)
  );

  always #5 clk = ~clk;

  function automatic int rule_now();
    if (rst) return 1;
    if (!rdy) return 2;
    if (mem_stall_req) return 3;
    if (branch_error) return 4;
    if (m_drain) return 5;
    if (id_stall_req) return 6;
    if (if_stall_req) return 7;
    return 8;
  endfunction

  // {pc, ifid, idex, exmem, memwb, flush_if}
  function automatic logic [10:0] exp_out();
    logic [9:0] c;
    int r = rule_now();
    case (r)
      1: c = 10'b10_10_10_10_10;
      2: c = 10'b01_01_01_01_01;
      3: c = 10'b01_01_01_01_10;
      4: c = 10'b00_10_10_00_00;
      5: c = 10'b01_10_00_00_00;
      6: c = 10'b01_01_10_00_00;
      7: c = 10'b01_10_00_00_00;
      default: c = 10'b0;
    endcase
    return {c, (r == 4) && if_busy};
  endfunction

  function automatic logic [159:0] exp_cnt();
`ifdef PIPE_PERF_CNT_EN
    return {m_cyc, m_mem, m_id, m_if, m_fl};
`else
    return 160'd0;
`endif
  endfunction

  function automatic logic [10:0] act_out();
    return {stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb, flush_if};
  endfunction

  function automatic logic [159:0] act_cnt();
    return {cnt_cycle, cnt_mem_stall, cnt_id_stall, cnt_if_stall, cnt_flush};
  endfunction

  // apply a stimulus word shortly after the edge, then wait to the sampling point
  task automatic drive(input logic [6:0] v);
    {rst, rdy, if_stall_req, if_busy, id_stall_req, mem_stall_req, branch_error} = v;
    @(negedge clk);
  endtask

  // advance the model by the rules of the cycle just checked, then cross the edge
  task automatic tick();
    int r = rule_now();
    if (rst) begin
      m_drain = 1'b0;
      {m_cyc, m_mem, m_id, m_if, m_fl} = '0;
    end else if (rdy) begin
      m_cyc++;
      if (r == 3) m_mem++;
      if (r == 4) begin m_fl++; m_drain = if_busy; end
      if (r == 5) m_drain = if_busy;
      if (r == 6) m_id++;
      if (r == 7) m_if++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(RSTB);
      n_vec++;
      if (act_out() !== 11'b10_10_10_10_10_0) begin
        n_bad++; $display("FAIL reset_out cyc%0d: got %b want %b", i, act_out(), 11'b10_10_10_10_10_0);
      end
      n_vec++;
      if (act_cnt() !== 160'd0) begin
        n_bad++; $display("FAIL reset_cnt cyc%0d: got %h want 0", i, act_cnt());
      end
      tick();
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 5; i++) begin
      drive(IDLE);
      n_vec++;
      if (act_out() !== 11'd0) begin
        n_bad++; $display("FAIL idle_out cyc%0d: got %b want 0", i, act_out());
      end
      n_vec++;
      if (act_cnt() !== exp_cnt()) begin
        n_bad++; $display("FAIL idle_cnt cyc%0d: got %h want %h", i, act_cnt(), exp_cnt());
      end
      tick();
    end
  endtask

  task automatic test_id_stall();
    logic [6:0] seq [3] = '{IDST, IDST, IDLE};
    for (int i = 0; i < 3; i++) begin
      drive(seq[i]);
      n_vec++;
      if (act_out() !== exp_out()) begin
        n_bad++; $display("FAIL id_stall_out cyc%0d: got %b want %b", i, act_out(), exp_out());
      end
      n_vec++;
      if (act_cnt() !== exp_cnt()) begin
        n_bad++; $display("FAIL id_stall_cnt cyc%0d: got %h want %h", i, act_cnt(), exp_cnt());
      end
      tick();
    end
  endtask

  task automatic test_mem_branch();
    logic [6:0] seq [2] = '{MEMBR, IDLE};
    for (int i = 0; i < 2; i++) begin
      drive(seq[i]);
      n_vec++;
      if (act_out() !== exp_out()) begin
        n_bad++; $display("FAIL mem_branch_out cyc%0d: got %b want %b", i, act_out(), exp_out());
      end
      n_vec++;
      if (act_cnt() !== exp_cnt()) begin
        n_bad++; $display("FAIL mem_branch_cnt cyc%0d: got %h want %h", i, act_cnt(), exp_cnt());
      end
      tick();
    end
  endtask

  task automatic test_drain();
    logic [6:0] seq [6] = '{BRB, BUSY, BUSY, BUSY, IDLE, IDLE};
    int drain_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      drive(seq[i]);
      if (i > 0 && stall_pc === 2'b01 && stall_ifid === 2'b10) drain_cycles++;
      n_vec++;
      if (act_out() !== exp_out()) begin
        n_bad++; $display("FAIL drain_out cyc%0d: got %b want %b", i, act_out(), exp_out());
      end
      n_vec++;
      if (act_cnt() !== exp_cnt()) begin
        n_bad++; $display("FAIL drain_cnt cyc%0d: got %h want %h", i, act_cnt(), exp_cnt());
      end
      tick();
    end
    n_vec++;
    if (drain_cycles != 4) begin
      n_bad++; $display("FAIL drain_len: got %0d want 4", drain_cycles);
    end
  endtask

  task automatic test_rdy_freeze();
    logic [6:0] seq [7] = '{BRB, BUSY, FRZB, FRZB, BUSY, IDLE, IDLE};
    for (int i = 0; i < 7; i++) begin
      drive(seq[i]);
      n_vec++;
      if (act_out() !== exp_out()) begin
        n_bad++; $display("FAIL freeze_out cyc%0d: got %b want %b", i, act_out(), exp_out());
      end
      n_vec++;
      if (act_cnt() !== exp_cnt()) begin
        n_bad++; $display("FAIL freeze_cnt cyc%0d: got %h want %h", i, act_cnt(), exp_cnt());
      end
      tick();
    end
  endtask

  task automatic test_rst_in_drain();
    logic [6:0] seq [5] = '{BRB, BUSY, RSTB, IDLE, IDLE};
    for (int i = 0; i < 5; i++) begin
      drive(seq[i]);
      n_vec++;
      if (act_out() !== exp_out()) begin
        n_bad++; $display("FAIL rst_drain_out cyc%0d: got %b want %b", i, act_out(), exp_out());
      end
      n_vec++;
      if (act_cnt() !== exp_cnt()) begin
        n_bad++; $display("FAIL rst_drain_cnt cyc%0d: got %h want %h", i, act_cnt(), exp_cnt());
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [6:0] v;
    for (int i = 0; i < 400; i++) begin
      v[6] = ($urandom_range(0, 49) == 0);
      v[5] = ($urandom_range(0, 9) != 0);
      v[4] = ($urandom_range(0, 3) == 0);
      v[3] = ($urandom_range(0, 1) == 0);
      v[2] = ($urandom_range(0, 4) == 0);
      v[1] = ($urandom_range(0, 5) == 0);
      v[0] = ($urandom_range(0, 4) == 0);
      drive(v);
      n_vec++;
      if (act_out() !== exp_out()) begin
        n_bad++; $display("FAIL random_out cyc%0d in=%b: got %b want %b", i, v, act_out(), exp_out());
      end
      n_vec++;
      if (act_cnt() !== exp_cnt()) begin
        n_bad++; $display("FAIL random_cnt cyc%0d: got %h want %h", i, act_cnt(), exp_cnt());
      end
      n_vec++;
      if (!rst && stall_pc === 2'b10) begin
        n_bad++; $display("FAIL random_pc_bubb cyc%0d: got %b want not 10", i, stall_pc);
      end
      tick();
    end
  endtask

  initial begin
    {rst, rdy, if_stall_req, if_busy, id_stall_req, mem_stall_req, branch_error} = RSTB;
    @(posedge clk);
    #1;
    test_reset();
    test_idle();
    test_id_stall();
    test_mem_branch();
    test_drain();
    test_rdy_freeze();
    test_rst_in_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush controller for the 5-stage RISC-V pipeline. It collects hazard and wait requests from the IF, ID and MEM stages and the branch-mispredict pulse from EX. Each cycle it drives one stall code to each of the five pipeline registers: PC, IF/ID, ID/EX, EX/MEM and MEM/WB. A small FSM discards an in-flight instruction fetch after a redirect, so wrong-path instructions never enter IF/ID.

## Interface
- No parameters. Stall codes come from config.v on `StallBus` (2 bits): `Pass`=2'b00 (load), `Hold`=2'b01 (keep), `Bubb`=2'b10 (clear to zero/nop).
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  chip ready; low freezes the whole pipeline
- if_stall_req  in  1  fetch result not yet available
- if_busy  in  1  memory fetch transaction in flight
- id_stall_req  in  1  load-use hazard detected in ID
- mem_stall_req  in  1  data-memory access not complete
- branch_error  in  1  EX mispredict; PC register loads branch_npc itself
- stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb  out  2 each  stall codes
- flush_if  out  1  one-cycle pulse telling IF to discard the in-flight fetch result
- cnt_cycle, cnt_mem_stall, cnt_id_stall, cnt_if_stall, cnt_flush  out  32 each  performance counters (see Configuration)

## Operation
- FSM states: RUN and DRAIN. Reset state is RUN.
- Stall codes are combinational from the inputs and the current state. Evaluate in priority order; the first match wins:
  1. rst: all five outputs `Bubb`; flush_if=0.
  2. !rdy: all `Hold`; the FSM and counters are frozen.
  3. mem_stall_req: pc, ifid, idex, exmem `Hold`; memwb `Bubb`.
  4. branch_error: pc `Pass`, ifid `Bubb`, idex `Bubb`, exmem `Pass`, memwb `Pass`.
     - flush_if=1 if if_busy.
     - Next state is DRAIN if if_busy, else RUN.
  5. state DRAIN: pc `Hold`, ifid `Bubb`, the rest `Pass`.
     - Leave for RUN on the cycle after if_busy is sampled low.
  6. id_stall_req: pc and ifid `Hold`; idex `Bubb`; the rest `Pass`.
  7. if_stall_req: pc `Hold`; ifid `Bubb`; the rest `Pass`.
  8. otherwise all `Pass`.
- Priority 3 keeps the current state.
  - A branch_error that coincides with mem_stall_req is not acted on. EX is held, so the branch re-asserts on the next unstalled cycle.
  - Redirecting the PC twice to the same target is harmless.
- A branch_error while in DRAIN stays in DRAIN and pulses flush_if again if if_busy.
- stall_pc is never `Bubb` outside reset. `Bubb` on the PC register overrides branch_npc and would lose the redirect target.

## Timing
- Stall-code latency is 0 cycles: combinational from inputs and state.
- flush_if is asserted in the same cycle as the qualifying branch_error. It is never asserted in any other cycle.
- FSM transitions occur on the posedge. DRAIN lasts at least 1 cycle: N+1 cycles if if_busy stays high for N cycles after entry.
- Reset values:
  - state=RUN.
  - All counters 0.
  - While rst is high the outputs are all `Bubb` and flush_if=0.
- A reset asserted during DRAIN returns to RUN on the next edge.
- Counters increment on the posedge when !rst && rdy. They wrap at 2^32.
  - cnt_cycle increments every such cycle.
  - Each stall counter increments only when its rule (3, 6 or 7) is the winning rule.
  - cnt_flush increments on every cycle that branch_error wins (rule 4).

## Configuration
- Macro: `PIPE_PERF_CNT_EN`.
- Defined: the five 32-bit counters are implemented as described under Timing.
- Undefined: no counter registers are built. All cnt_* outputs are tied to 32'd0. Stall codes, flush_if and FSM behaviour are identical.

## Test plan
- Reset, then idle inputs with rdy=1: every stall output is 2'b00; cnt_cycle equals the number of post-reset cycles.
- id_stall_req=1 for 2 cycles: pc=ifid=2'b01, idex=2'b10, exmem=memwb=2'b00 in both cycles; cnt_id_stall=2.
- mem_stall_req and branch_error both high for 1 cycle: pc..exmem=2'b01, memwb=2'b10; flush_if=0; state stays RUN; cnt_flush=0.
- branch_error pulse with if_busy=1, then if_busy held high 3 more cycles:
  - Pulse cycle: flush_if=1, ifid=idex=2'b10.
  - Then 4 DRAIN cycles with pc=2'b01, ifid=2'b10.
  - Then RUN; cnt_flush=1.
- rdy=0 in mid-DRAIN for 2 cycles: all outputs 2'b01; state and counters unchanged; DRAIN resumes after rdy=1.
- rst asserted in DRAIN: all outputs 2'b10; next cycle after deassert is RUN with all 2'b00; counters 0 (or 0 constantly with the macro undefined).
